// File: rtl/inference_sequencer_pkg.sv
// Shared types and defaults for the inference run controller.
package Sequencer;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SRST  = 3'd1,
        ST_ARM   = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_FIN   = 3'd5
    } SeqState;

    localparam int unsigned DEFAULT_TIMEOUT_BIT = 29;
    localparam int unsigned FINISH_DELAY        = 10;

endpackage

// File: rtl/inference_sequencer_timer.sv
// Saturating cycle timer with clear, enable and a selectable-bit timeout flag.
module seq_timer #(
    parameter  int unsigned W           = 32,
    parameter  int unsigned DEFAULT_BIT = Sequencer::DEFAULT_TIMEOUT_BIT,
    localparam int unsigned SEL_W       = $clog2(W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic [W-1:0]     count_o,
    output logic             hit_o
);

    logic [W-1:0]     count_q, count_d;
    logic [SEL_W-1:0] sel_eff;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    // A zero select means "use the default bit", so bit 0 can never be chosen.
    always_comb begin
        sel_eff = (sel_i == '0) ? SEL_W'(DEFAULT_BIT) : sel_i;
        hit_o   = count_q[sel_eff];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/inference_sequencer.sv
// Run controller for one inference section: soft-reset hold, arm, run, drain, done/timeout.
module inference_sequencer #(
    parameter int unsigned TIMER_W             = 32,
    parameter int unsigned LAYER_W             = 8,
    parameter int unsigned RESET_HOLD          = 64,
    parameter int unsigned FINISH_DELAY        = Sequencer::FINISH_DELAY,
    parameter int unsigned DEFAULT_TIMEOUT_BIT = Sequencer::DEFAULT_TIMEOUT_BIT
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       run,
    input  logic                       reset_req,
    input  logic [$clog2(TIMER_W)-1:0] timeout_bit,
    input  logic                       load_done,
    input  logic                       layer_done,
    input  logic                       islastlayer,
    input  logic                       islast_inbatch,
    input  logic                       result_half_full,
    output logic                       start,
    output logic                       soft_resetn,
    output logic                       busy,
    output logic                       done,
    output logic                       timed_out,
    output logic                       run_dropped,
    output logic [LAYER_W-1:0]         layer_count,
    output logic [TIMER_W-1:0]         cycles,
    output logic                       top_ready
);

    import Sequencer::SeqState, Sequencer::ST_IDLE, Sequencer::ST_SRST, Sequencer::ST_ARM,
           Sequencer::ST_RUN, Sequencer::ST_DRAIN, Sequencer::ST_FIN;

    localparam int unsigned HOLD_W  = $clog2(RESET_HOLD + 1);
    localparam int unsigned DRAIN_W = $clog2(FINISH_DELAY + 1);

    SeqState              state_q, state_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic [LAYER_W-1:0]   layer_q, layer_d;
    logic [TIMER_W-1:0]   cycles_q, cycles_d;
    logic                 timed_out_q, timed_out_d;
    logic                 run_dropped_q, run_dropped_d;
    logic                 start_q, done_q, busy_q, soft_resetn_q, top_ready_q;

    logic                 timer_clr, timer_en, timer_hit;
    logic [TIMER_W-1:0]   timer_count;

    seq_timer #(
        .W           (TIMER_W),
        .DEFAULT_BIT (DEFAULT_TIMEOUT_BIT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (resetn),
        .clr_i   (timer_clr),
        .en_i    (timer_en),
        .sel_i   (timeout_bit),
        .count_o (timer_count),
        .hit_o   (timer_hit)
    );

    assign timer_en = (state_q == ST_ARM) || (state_q == ST_RUN) || (state_q == ST_DRAIN);

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        drain_d       = drain_q;
        layer_d       = layer_q;
        timed_out_d   = timed_out_q;
        run_dropped_d = run_dropped_q;
        timer_clr     = 1'b0;

        if (reset_req) begin
            state_d       = ST_SRST;
            hold_d        = HOLD_W'(RESET_HOLD - 1);
            run_dropped_d = 1'b0;
        end else begin
            if (run && (state_q != ST_IDLE)) begin
                run_dropped_d = 1'b1;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        state_d     = ST_ARM;
                        timer_clr   = 1'b1;
                        layer_d     = '0;
                        timed_out_d = 1'b0;
                    end
                end
                ST_SRST: begin
                    if (hold_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        hold_d = hold_q - HOLD_W'(1);
                    end
                end
                ST_ARM: begin
                    if (timer_hit) begin
                        state_d     = ST_FIN;
                        timed_out_d = 1'b1;
                    end else if (load_done) begin
                        state_d = ST_RUN;
                    end
                end
                // A layer finishing on the timeout cycle still counts; timeout owns the transition.
                ST_RUN: begin
                    if (layer_done) begin
                        layer_d = layer_q + LAYER_W'(1);
                    end
                    if (timer_hit) begin
                        state_d     = ST_FIN;
                        timed_out_d = 1'b1;
                    end else if (layer_done && islastlayer && islast_inbatch) begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_W'(FINISH_DELAY - 1);
                    end
                end
                ST_DRAIN: begin
                    if (timer_hit) begin
                        state_d     = ST_FIN;
                        timed_out_d = 1'b1;
                    end else if (drain_q == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        drain_d = drain_q - DRAIN_W'(1);
                    end
                end
                ST_FIN:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        cycles_d = (state_d == ST_FIN) ? timer_count : cycles_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            hold_q        <= '0;
            drain_q       <= '0;
            layer_q       <= '0;
            cycles_q      <= '0;
            timed_out_q   <= 1'b0;
            run_dropped_q <= 1'b0;
            start_q       <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            soft_resetn_q <= 1'b0;
            top_ready_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            drain_q       <= drain_d;
            layer_q       <= layer_d;
            cycles_q      <= cycles_d;
            timed_out_q   <= timed_out_d;
            run_dropped_q <= run_dropped_d;
            start_q       <= (state_q == ST_ARM) && (state_d == ST_RUN);
            done_q        <= (state_d == ST_FIN);
            busy_q        <= (state_d != ST_IDLE);
            soft_resetn_q <= (state_d != ST_SRST);
            top_ready_q   <= !result_half_full;
        end
    end

    assign start       = start_q;
    assign soft_resetn = soft_resetn_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timed_out   = timed_out_q;
    assign run_dropped = run_dropped_q;
    assign layer_count = layer_q;
    assign cycles      = cycles_q;
    assign top_ready   = top_ready_q;

endmodule

// File: tb/tb_inference_sequencer.sv
// Directed self-checking bench for inference_sequencer.
module tb_inference_sequencer;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        run = 1'b0;
    logic        reset_req = 1'b0;
    logic [4:0]  timeout_bit = 5'd0;
    logic        load_done = 1'b0;
    logic        layer_done = 1'b0;
    logic        islastlayer = 1'b0;
    logic        islast_inbatch = 1'b0;
    logic        result_half_full = 1'b0;
    logic        start, soft_resetn, busy, done, timed_out, run_dropped, top_ready;
    logic [7:0]  layer_count;
    logic [31:0] cycles;

    int checks = 0;
    int failures = 0;

    inference_sequencer #(
        .TIMER_W             (32),
        .LAYER_W             (8),
        .RESET_HOLD          (64),
        .FINISH_DELAY        (10),
        .DEFAULT_TIMEOUT_BIT (29)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .run              (run),
        .reset_req        (reset_req),
        .timeout_bit      (timeout_bit),
        .load_done        (load_done),
        .layer_done       (layer_done),
        .islastlayer      (islastlayer),
        .islast_inbatch   (islast_inbatch),
        .result_half_full (result_half_full),
        .start            (start),
        .soft_resetn      (soft_resetn),
        .busy             (busy),
        .done             (done),
        .timed_out        (timed_out),
        .run_dropped      (run_dropped),
        .layer_count      (layer_count),
        .cycles           (cycles),
        .top_ready        (top_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_soft_high(output int n, output logic saw_done);
        n = 0;
        saw_done = 1'b0;
        while (soft_resetn !== 1'b1 && n < 200) begin
            tick();
            n++;
            if (done === 1'b1) saw_done = 1'b1;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int   n;
        logic sd;

        // Asynchronous reset and reset values
        #2 resetn = 1'b0;
        #1;
        chk("rst_soft_resetn", soft_resetn, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", start, 0);
        chk("rst_done", done, 0);
        chk("rst_top_ready", top_ready, 0);
        chk("rst_layer_count", layer_count, 0);
        chk("rst_cycles", cycles, 0);
        tick(); tick();
        chk("rst_hold_soft", soft_resetn, 0);
        resetn = 1'b1;
        tick();
        chk("rel_soft_resetn", soft_resetn, 1);
        chk("rel_top_ready", top_ready, 1);
        chk("rel_busy", busy, 0);

        // Normal run
        reset_req = 1'b1; tick(); reset_req = 1'b0;
        chk("srst_soft_low", soft_resetn, 0);
        chk("srst_busy", busy, 1);
        wait_soft_high(n, sd);
        chk("srst_hold_len", n, 64);
        chk("srst_idle_busy", busy, 0);

        run = 1'b1; tick(); run = 1'b0;            // edge R
        chk("arm_busy", busy, 1);
        chk("arm_layer_count", layer_count, 0);
        chk("arm_start", start, 0);
        repeat (4) tick();
        load_done = 1'b1; tick(); load_done = 1'b0; // edge R+5
        chk("run_start_pulse", start, 1);
        tick();
        chk("run_start_once", start, 0);
        for (int i = 0; i < 3; i++) begin
            layer_done = 1'b1;
            islastlayer = (i == 2);
            islast_inbatch = (i == 2);
            tick();
            layer_done = 1'b0; islastlayer = 1'b0; islast_inbatch = 1'b0;
            if (i < 2) tick();
        end                                          // last layer at edge R+11
        chk("run_layer_count", layer_count, 3);
        chk("drain_no_done", done, 0);
        wait_done(n);
        chk("drain_len", n, 10);
        chk("fin_cycles", cycles, 20);
        chk("fin_timed_out", timed_out, 0);
        chk("fin_busy", busy, 1);
        tick();
        chk("fin_done_once", done, 0);
        chk("fin_idle_busy", busy, 0);
        chk("fin_cycles_frozen", cycles, 20);

        // Run while busy
        run = 1'b1; tick(); run = 1'b0;
        load_done = 1'b1; tick(); load_done = 1'b0;
        layer_done = 1'b1; tick(); layer_done = 1'b0;
        chk("rwb_layer1", layer_count, 1);
        run = 1'b1; tick(); run = 1'b0;
        chk("rwb_dropped", run_dropped, 1);
        chk("rwb_layer_kept", layer_count, 1);
        chk("rwb_busy", busy, 1);
        layer_done = 1'b1; islastlayer = 1'b1; islast_inbatch = 1'b1; tick();
        layer_done = 1'b0; islastlayer = 1'b0; islast_inbatch = 1'b0;
        wait_done(n);
        chk("rwb_done_seen", done, 1);
        chk("rwb_layer_final", layer_count, 2);
        tick();
        chk("rwb_dropped_sticky", run_dropped, 1);
        reset_req = 1'b1; tick(); reset_req = 1'b0;
        chk("rwb_dropped_clr", run_dropped, 0);
        wait_soft_high(n, sd);
        chk("rwb_srst_len", n, 64);

        // Timeout with load_done withheld
        timeout_bit = 5'd4;
        run = 1'b1; tick(); run = 1'b0;            // edge R, timer 0
        wait_done(n);
        chk("to_latency", n, 17);
        chk("to_timed_out", timed_out, 1);
        chk("to_cycles", cycles, 16);
        chk("to_layer_count", layer_count, 0);
        tick();
        chk("to_idle", busy, 0);
        chk("to_sticky", timed_out, 1);

        // Next run clears timed_out; then timeout collides with qualified layer_done
        run = 1'b1; tick(); run = 1'b0;            // edge R
        chk("to_cleared", timed_out, 0);
        load_done = 1'b1; tick(); load_done = 1'b0; // edge R+1
        chk("col_start", start, 1);
        repeat (15) tick();                          // edge R+16, timer 16
        chk("col_not_yet", done, 0);
        layer_done = 1'b1; islastlayer = 1'b1; islast_inbatch = 1'b1; tick();
        layer_done = 1'b0; islastlayer = 1'b0; islast_inbatch = 1'b0;
        chk("col_done", done, 1);
        chk("col_timed_out", timed_out, 1);
        chk("col_layer_count", layer_count, 1);
        chk("col_cycles", cycles, 16);
        tick();
        chk("col_idle", busy, 0);
        timeout_bit = 5'd0;

        // Reset request during DRAIN
        run = 1'b1; tick(); run = 1'b0;
        load_done = 1'b1; tick(); load_done = 1'b0;
        layer_done = 1'b1; islastlayer = 1'b1; islast_inbatch = 1'b1; tick();
        layer_done = 1'b0; islastlayer = 1'b0; islast_inbatch = 1'b0;
        repeat (3) tick();
        chk("mid_drain_busy", busy, 1);
        reset_req = 1'b1; tick(); reset_req = 1'b0;
        chk("mid_soft_low", soft_resetn, 0);
        wait_soft_high(n, sd);
        chk("mid_srst_len", n, 64);
        chk("mid_no_done", sd, 0);
        chk("mid_idle_busy", busy, 0);
        repeat (12) tick();
        chk("mid_still_no_done", done, 0);

        // run and reset_req together: reset wins, no run_dropped
        run = 1'b1; reset_req = 1'b1; tick(); run = 1'b0; reset_req = 1'b0;
        chk("rr_soft_low", soft_resetn, 0);
        chk("rr_no_dropped", run_dropped, 0);
        wait_soft_high(n, sd);
        chk("rr_srst_len", n, 64);
        chk("rr_idle", busy, 0);

        // top_ready follows !result_half_full one cycle later
        result_half_full = 1'b1; tick();
        chk("tr_low", top_ready, 0);
        result_half_full = 1'b0; tick();
        chk("tr_high", top_ready, 1);

        // Asynchronous reset mid-RUN
        run = 1'b1; tick(); run = 1'b0;
        load_done = 1'b1; tick(); load_done = 1'b0;
        layer_done = 1'b1; tick(); layer_done = 1'b0;
        run = 1'b1; tick(); run = 1'b0;
        chk("ar_pre_dropped", run_dropped, 1);
        chk("ar_pre_layer", layer_count, 1);
        #2 resetn = 1'b0;
        #1;
        chk("ar_soft_resetn", soft_resetn, 0);
        chk("ar_busy", busy, 0);
        chk("ar_start", start, 0);
        chk("ar_done", done, 0);
        chk("ar_timed_out", timed_out, 0);
        chk("ar_run_dropped", run_dropped, 0);
        chk("ar_layer_count", layer_count, 0);
        chk("ar_cycles", cycles, 0);
        chk("ar_top_ready", top_ready, 0);
        tick();
        resetn = 1'b1;
        tick();
        chk("ar_release_soft", soft_resetn, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inference_sequencer.md
Name: inference_sequencer

Overview:
- Top-level run controller that sequences one inference section: soft-reset hold, wait for parameter load, start pulse, layer tracking, drain, done/timeout reporting.
- Sits between the decoded top-instruction register writes and the `mem`/`arith` datapath start/reset inputs.
- Replaces the scattered posedge/on-off/counter glue with a single FSM and a cycle timer.

Parameters:
- TIMER_W, 32, width of the cycle timer and the `cycles` output.
- LAYER_W, 8, width of the layer counter.
- RESET_HOLD, 64, cycles `soft_resetn` is held low per reset request (≥2).
- FINISH_DELAY, 10, drain cycles after the last layer before `done`, so in-flight FIFO writes land.
- DEFAULT_TIMEOUT_BIT, 29, timer bit used when `timeout_bit == 0`.

Ports:
- clk  input  1  single clock for the whole block.
- resetn  input  1  reset, asynchronous assert, active low; this fixes the reset values of all outputs and state.
- run  input  1  single-cycle run request (decoded register write).
- reset_req  input  1  single-cycle soft-reset request.
- timeout_bit  input  $clog2(TIMER_W)  timer bit that triggers timeout; 0 selects DEFAULT_TIMEOUT_BIT.
- load_done  input  1  layer params/instructions are loaded; level or pulse.
- layer_done  input  1  pulse: one layer fully written to layerio memory.
- islastlayer  input  1  qualifies `layer_done`.
- islast_inbatch  input  1  qualifies `layer_done`.
- result_half_full  input  1  result FIFO back-pressure.
- start  output  1  one-cycle start pulse to `mem`/`arith`.
- soft_resetn  output  1  active-low soft reset to the datapath.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- timed_out  output  1  sticky; set by timeout, cleared by the next accepted `run`.
- run_dropped  output  1  sticky; set when `run` arrives while busy, cleared by `reset_req`.
- layer_count  output  LAYER_W  layers completed in the current run; wraps modulo 2^LAYER_W.
- cycles  output  TIMER_W  timer value frozen at completion.
- top_ready  output  1  registered `!result_half_full`.

Behaviour:
- Reset values (on `resetn` low): state IDLE; `soft_resetn` 0; `start`, `busy`, `done`, `timed_out`, `run_dropped`, `top_ready` 0; `layer_count` 0; `cycles` 0; internal timer 0.
- After `resetn` deasserts, `soft_resetn` rises on the first clk edge.
- FSM states: IDLE, SRST, ARM, RUN, DRAIN, FIN.
- IDLE:
  - `run` → ARM; clears timer, `layer_count` and `timed_out`.
  - `reset_req` → SRST.
- SRST:
  - `soft_resetn` = 0 for exactly RESET_HOLD cycles (hold counter), then → IDLE.
  - `reset_req` received in any state, including SRST, forces SRST and restarts the hold count.
  - `reset_req` has top priority over every other event.
- ARM:
  - Timer runs from ARM entry.
  - `load_done` → RUN. `start` is asserted for exactly one cycle, the first cycle in RUN (registered; 1 cycle after `load_done` is sampled).
- RUN:
  - `layer_done` increments `layer_count`.
  - `layer_done & islastlayer & islast_inbatch` → DRAIN.
- DRAIN:
  - Stays FINISH_DELAY cycles; the timer keeps running; then → FIN.
- FIN:
  - One cycle. `done` = 1, `cycles` latches the timer, → IDLE.
- Timeout:
  - In ARM, RUN or DRAIN, when `timer[sel_bit]` is 1: set `timed_out` and go directly to FIN.
  - `sel_bit` = `timeout_bit`, or DEFAULT_TIMEOUT_BIT when `timeout_bit == 0`.
  - Timeout and `layer_done` in the same cycle: the layer still counts; timeout wins the transition.
- The timer saturates at all-ones; it never wraps.
- `run` while `busy` is ignored and sets `run_dropped`.
- `run` and `reset_req` in the same cycle: reset wins; the run is dropped without setting `run_dropped`.
- `layer_done` outside RUN is ignored.
- `busy` = (state != IDLE), registered together with the state.
- `top_ready` is a 1-cycle registered copy of `!result_half_full` in all states.

Decomposition:
- Add to a shared package `Sequencer`:
  - state enum `SeqState`;
  - constant DEFAULT_TIMEOUT_BIT;
  - constant FINISH_DELAY.
- One sub-module: `seq_timer`. It is the saturating TIMER_W counter with clear, enable and selectable-bit timeout compare, and it is reusable for perf recording.
- The FSM, hold counter and drain counter stay in the top of the block.

Test Plan:
- Normal run: `reset_req` pulse, then after RESET_HOLD `run`, `load_done` 5 cycles later, 3 `layer_done` pulses with the last qualified → `soft_resetn` low exactly 64 cycles; `start` high one cycle; `layer_count`=3; `done` pulse FINISH_DELAY+1 cycles after the last layer; `timed_out`=0.
- Timeout: `timeout_bit`=4, `run`, withhold `load_done` → `timed_out`=1 and `done` 1 cycle after timer bit 4 sets (timer=16); next `run` clears `timed_out`.
- Run while busy: second `run` during RUN → ignored, `run_dropped`=1, `layer_count` unaffected; a later `reset_req` clears `run_dropped`.
- Reset mid-run: `reset_req` during DRAIN → no `done`; `soft_resetn` low 64 cycles; returns to IDLE with `busy`=0.
- Collision: timeout and qualified `layer_done` in the same cycle → `layer_count` increments, state goes to FIN, `timed_out`=1.
- Async reset: drop `resetn` mid-RUN without a clock edge → all outputs immediately at reset values.
